// File: rtl/vga_scan_if.sv
// Raster output bundle of the VGA scan timing block.
// The master side (vga_scan_timing) drives the pixel coordinates, frame and
// vblank ticks and the delayed sync/de levels; consumers attach to the slave side.
// Optional macro VGA_SCAN_FRAME_CNT_EN adds the 8-bit frame_cnt signal.
`timescale 1ns/1ps

interface vga_scan_if #(
  parameter int COORD_W = 10
);
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               pix_active;
  logic               frame_start;
  logic               vblank_tick;
  logic               hsync;
  logic               vsync;
  logic               de;
`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [7:0]         frame_cnt;
`endif

  modport master (
    output pix_x, pix_y, pix_active, frame_start, vblank_tick, hsync, vsync, de
`ifdef VGA_SCAN_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input pix_x, pix_y, pix_active, frame_start, vblank_tick, hsync, vsync, de
`ifdef VGA_SCAN_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_scan_timing.sv
// VGA scan timing generator.
// Free-running horizontal/vertical raster counters, a registered stage that
// presents pixel coordinates and frame/vblank ticks one cycle after the
// counters, and a PIPE_DELAY-deep shift register that delays hsync/vsync/de so
// they line up with a downstream graphics pipeline.
// Optional macro VGA_SCAN_FRAME_CNT_EN adds an 8-bit wrapping frame counter.
`timescale 1ns/1ps

module vga_scan_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int PIPE_DELAY = 2,
  parameter int COORD_W    = 10
) (
  input  logic      clk_in,
  input  logic      resetn,
  vga_scan_if.master scan
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  // Output levels: asserted level equals the POL parameter, inactive is its inverse.
  localparam logic HS_ON  = (HSYNC_POL != 0);
  localparam logic HS_OFF = !HS_ON;
  localparam logic VS_ON  = (VSYNC_POL != 0);
  localparam logic VS_OFF = !VS_ON;

  logic [COORD_W-1:0] h_cnt_p0;
  logic [COORD_W-1:0] v_cnt_p0;

  logic               h_act_p0;
  logic               v_act_p0;
  logic               hs_win_p0;
  logic               vs_win_p0;
  logic               at_origin_p0;
  logic               at_vblank_p0;

  logic [COORD_W-1:0] pix_x_p1;
  logic [COORD_W-1:0] pix_y_p1;
  logic               active_p1;
  logic               frame_start_p1;
  logic               vblank_tick_p1;
  logic               hs_p1;
  logic               vs_p1;

  // Raster counters: h steps every clock, v steps on the h wrap, both wrap together at frame end.
  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (h_cnt_p0 == H_LAST) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + 1'b1;
    end else begin
      h_cnt_p0 <= h_cnt_p0 + 1'b1;
    end
  end

  // Region decode of the current counter position; vsync depends on v only, so it moves at h = 0.
  always_comb begin
    h_act_p0     = (h_cnt_p0 < H_ACT);
    v_act_p0     = (v_cnt_p0 < V_ACT);
    hs_win_p0    = (h_cnt_p0 >= HS_BEG) && (h_cnt_p0 < HS_END);
    vs_win_p0    = (v_cnt_p0 >= VS_BEG) && (v_cnt_p0 < VS_END);
    at_origin_p0 = (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
    at_vblank_p0 = (h_cnt_p0 == '0) && (v_cnt_p0 == V_ACT);
  end

  // ---- stage 1: registered coordinates, ticks and raw sync levels ----
  // Register the decoded counter state so every consumer sees it one cycle later.
  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      pix_x_p1       <= '0;
      pix_y_p1       <= '0;
      active_p1      <= 1'b0;
      frame_start_p1 <= 1'b0;
      vblank_tick_p1 <= 1'b0;
      hs_p1          <= HS_OFF;
      vs_p1          <= VS_OFF;
    end else begin
      pix_x_p1       <= h_cnt_p0;
      pix_y_p1       <= v_cnt_p0;
      active_p1      <= h_act_p0 && v_act_p0;
      frame_start_p1 <= at_origin_p0;
      vblank_tick_p1 <= at_vblank_p0;
      hs_p1          <= hs_win_p0 ? HS_ON : HS_OFF;
      vs_p1          <= vs_win_p0 ? VS_ON : VS_OFF;
    end
  end

  assign scan.pix_x       = pix_x_p1;
  assign scan.pix_y       = pix_y_p1;
  assign scan.pix_active  = active_p1;
  assign scan.frame_start = frame_start_p1;
  assign scan.vblank_tick = vblank_tick_p1;

`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [7:0] frame_cnt_p1;

  // Frame counter loads its new value on the same edge that raises frame_start.
  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      frame_cnt_p1 <= 8'd0;
    end else if (at_origin_p0) begin
      frame_cnt_p1 <= frame_cnt_p1 + 8'd1;
    end
  end

  assign scan.frame_cnt = frame_cnt_p1;
`endif

  // ---- stage 2..(1+PIPE_DELAY): sync/de alignment delay ----
  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign scan.hsync = hs_p1;
      assign scan.vsync = vs_p1;
      assign scan.de    = active_p1;
    end else begin : g_delay
      logic [PIPE_DELAY-1:0] hs_sr;
      logic [PIPE_DELAY-1:0] vs_sr;
      logic [PIPE_DELAY-1:0] de_sr;

      // Shift the stage-1 sync/de levels; reset fills every tap with the inactive level.
      always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
          hs_sr <= {PIPE_DELAY{HS_OFF}};
          vs_sr <= {PIPE_DELAY{VS_OFF}};
          de_sr <= '0;
        end else begin
          hs_sr[0] <= hs_p1;
          vs_sr[0] <= vs_p1;
          de_sr[0] <= active_p1;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            hs_sr[i] <= hs_sr[i-1];
            vs_sr[i] <= vs_sr[i-1];
            de_sr[i] <= de_sr[i-1];
          end
        end
      end

      assign scan.hsync = hs_sr[PIPE_DELAY-1];
      assign scan.vsync = vs_sr[PIPE_DELAY-1];
      assign scan.de    = de_sr[PIPE_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_scan_timing.sv
// Self-checking bench for vga_scan_timing using a reduced raster geometry.
// Two instances: A (PIPE_DELAY=2, hsync active-high, vsync active-low) and
// B (PIPE_DELAY=0, hsync active-low, vsync active-high).
// Define VGA_SCAN_FRAME_CNT_EN to also exercise the frame counter.
`timescale 1ns/1ps

module tb_vga_scan_timing;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int CW = 10;

  localparam int DA = 2, HPA = 1, VPA = 0;
  localparam int DB = 0, HPB = 0, VPB = 1;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          act;
    logic          fs;
    logic          vb;
    logic          hs;
    logic          vs;
    logic          de;
    logic [7:0]    fc;
  } snap_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   k;
  int   n_chk = 0;
  int   n_fail = 0;

  vga_scan_if #(.COORD_W(CW)) bus_a ();
  vga_scan_if #(.COORD_W(CW)) bus_b ();

  vga_scan_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(HPA), .VSYNC_POL(VPA), .PIPE_DELAY(DA), .COORD_W(CW)
  ) dut_a (
    .clk_in(clk), .resetn(resetn), .scan(bus_a.master)
  );

  vga_scan_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(HPB), .VSYNC_POL(VPB), .PIPE_DELAY(DB), .COORD_W(CW)
  ) dut_b (
    .clk_in(clk), .resetn(resetn), .scan(bus_b.master)
  );

  always #5 clk = ~clk;

  // Number of active clock edges since the last reset release.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) k <= 0;
    else         k <= k + 1;
  end

  // Reference: after edge n the stage-1 outputs show raster position n-1,
  // and the sync/de outputs show position n-1-d (inactive before that).
  function automatic snap_t model(int n, int d, int hp, int vp);
    snap_t e;
    int p, x, y;
    e.x = '0; e.y = '0; e.act = 1'b0; e.fs = 1'b0; e.vb = 1'b0;
    e.hs = (hp == 0); e.vs = (vp == 0); e.de = 1'b0; e.fc = 8'd0;
    if (n >= 1) begin
      p = n - 1;
      x = p % HT;
      y = (p / HT) % VT;
      e.x   = CW'(x);
      e.y   = CW'(y);
      e.act = (x < HA) && (y < VA);
      e.fs  = (x == 0) && (y == 0);
      e.vb  = (x == 0) && (y == VA);
`ifdef VGA_SCAN_FRAME_CNT_EN
      e.fc  = 8'(((p / FT) + 1) % 256);
`endif
    end
    if (n - 1 - d >= 0) begin
      p = n - 1 - d;
      x = p % HT;
      y = (p / HT) % VT;
      e.hs = ((x >= HA + HF) && (x < HA + HF + HS)) ? (hp != 0) : (hp == 0);
      e.vs = ((y >= VA + VF) && (y < VA + VF + VS)) ? (vp != 0) : (vp == 0);
      e.de = (x < HA) && (y < VA);
    end
    return e;
  endfunction

  function automatic snap_t get_a();
    snap_t s;
    s.x = bus_a.pix_x; s.y = bus_a.pix_y; s.act = bus_a.pix_active;
    s.fs = bus_a.frame_start; s.vb = bus_a.vblank_tick;
    s.hs = bus_a.hsync; s.vs = bus_a.vsync; s.de = bus_a.de;
`ifdef VGA_SCAN_FRAME_CNT_EN
    s.fc = bus_a.frame_cnt;
`else
    s.fc = 8'd0;
`endif
    return s;
  endfunction

  function automatic snap_t get_b();
    snap_t s;
    s.x = bus_b.pix_x; s.y = bus_b.pix_y; s.act = bus_b.pix_active;
    s.fs = bus_b.frame_start; s.vb = bus_b.vblank_tick;
    s.hs = bus_b.hsync; s.vs = bus_b.vsync; s.de = bus_b.de;
`ifdef VGA_SCAN_FRAME_CNT_EN
    s.fc = bus_b.frame_cnt;
`else
    s.fc = 8'd0;
`endif
    return s;
  endfunction

  task automatic test_reset();
    snap_t ea, eb, aa, ab;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    ea = model(0, DA, HPA, VPA);
    eb = model(0, DB, HPB, VPB);
    aa = get_a();
    ab = get_b();
    n_chk++;
    if (aa !== ea) begin
      n_fail++;
      $display("FAIL reset_a: got %h expected %h", aa, ea);
    end
    n_chk++;
    if (ab !== eb) begin
      n_fail++;
      $display("FAIL reset_b: got %h expected %h", ab, eb);
    end
    n_chk++;
    if (bus_a.hsync !== 1'b0 || bus_b.hsync !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hsync_pol: got a=%b b=%b expected a=0 b=1", bus_a.hsync, bus_b.hsync);
    end
  endtask

  task automatic test_first_edge();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus_b.pix_x !== '0 || bus_b.pix_y !== '0 || bus_b.frame_start !== 1'b1 || bus_b.de !== 1'b1) begin
      n_fail++;
      $display("FAIL first_edge_b: got x=%0d y=%0d fs=%b de=%b expected x=0 y=0 fs=1 de=1",
               bus_b.pix_x, bus_b.pix_y, bus_b.frame_start, bus_b.de);
    end
    n_chk++;
    if (bus_a.pix_active !== 1'b1 || bus_a.de !== 1'b0) begin
      n_fail++;
      $display("FAIL first_edge_a: got act=%b de=%b expected act=1 de=0", bus_a.pix_active, bus_a.de);
    end
    @(negedge clk);
    n_chk++;
    if (bus_a.de !== 1'b0) begin
      n_fail++;
      $display("FAIL de_lag_edge2: got de=%b expected 0", bus_a.de);
    end
    @(negedge clk);
    n_chk++;
    if (bus_a.de !== 1'b1) begin
      n_fail++;
      $display("FAIL de_lag_edge3: got de=%b expected 1", bus_a.de);
    end
  endtask

  task automatic test_raster(int cycles);
    snap_t ea, eb, aa, ab;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      ea = model(k, DA, HPA, VPA);
      eb = model(k, DB, HPB, VPB);
      aa = get_a();
      ab = get_b();
      n_chk++;
      if (aa !== ea) begin
        n_fail++;
        $display("FAIL raster_a k=%0d: got %h expected %h", k, aa, ea);
      end
      n_chk++;
      if (ab !== eb) begin
        n_fail++;
        $display("FAIL raster_b k=%0d: got %h expected %h", k, ab, eb);
      end
    end
  endtask

  task automatic test_line_hsync();
    int guard, cnt_a, cnt_b, first_a, first_b;
    guard = 0;
    @(negedge clk);
    while (bus_b.pix_x !== '0 && guard < HT + 2) begin
      @(negedge clk);
      guard++;
    end
    n_chk++;
    if (bus_b.pix_x !== '0) begin
      n_fail++;
      $display("FAIL line_start_wait: got x=%0d expected 0", bus_b.pix_x);
    end
    cnt_a = 0; cnt_b = 0; first_a = -1; first_b = -1;
    for (int i = 0; i < HT; i++) begin
      if (bus_a.hsync === 1'b1) begin
        if (first_a < 0) first_a = int'(bus_a.pix_x);
        cnt_a++;
      end
      if (bus_b.hsync === 1'b0) begin
        if (first_b < 0) first_b = int'(bus_b.pix_x);
        cnt_b++;
      end
      @(negedge clk);
    end
    n_chk++;
    if (cnt_b != HS || first_b != HA + HF) begin
      n_fail++;
      $display("FAIL hsync_window_b: got len=%0d start=%0d expected len=%0d start=%0d",
               cnt_b, first_b, HS, HA + HF);
    end
    n_chk++;
    if (cnt_a != HS || first_a != HA + HF + DA) begin
      n_fail++;
      $display("FAIL hsync_window_a: got len=%0d start=%0d expected len=%0d start=%0d",
               cnt_a, first_a, HS, HA + HF + DA);
    end
  endtask

  task automatic test_frame();
    int guard, len, vs_b, vs_a, vb_cnt, vb_x, vb_y, vs_x, vs_y;
    guard = 0;
    @(negedge clk);
    while (bus_b.frame_start !== 1'b1 && guard < FT + 2) begin
      @(negedge clk);
      guard++;
    end
    n_chk++;
    if (bus_b.frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_start_wait: got fs=%b expected 1", bus_b.frame_start);
    end
    len = 0; vs_b = 0; vs_a = 0; vb_cnt = 0; vb_x = -1; vb_y = -1; vs_x = -1; vs_y = -1;
    do begin
      if (bus_b.vsync === 1'b1) begin
        if (vs_x < 0) begin vs_x = int'(bus_b.pix_x); vs_y = int'(bus_b.pix_y); end
        vs_b++;
      end
      if (bus_a.vsync === 1'b0) vs_a++;
      if (bus_b.vblank_tick === 1'b1) begin
        vb_cnt++; vb_x = int'(bus_b.pix_x); vb_y = int'(bus_b.pix_y);
      end
      @(negedge clk);
      len++;
    end while (bus_b.frame_start !== 1'b1 && len < FT + 5);
    n_chk++;
    if (len != FT) begin
      n_fail++;
      $display("FAIL frame_period: got %0d cycles expected %0d", len, FT);
    end
    n_chk++;
    if (vs_b != VS * HT || vs_x != 0 || vs_y != VA + VF) begin
      n_fail++;
      $display("FAIL vsync_window_b: got len=%0d at (%0d,%0d) expected len=%0d at (0,%0d)",
               vs_b, vs_x, vs_y, VS * HT, VA + VF);
    end
    n_chk++;
    if (vs_a != VS * HT) begin
      n_fail++;
      $display("FAIL vsync_len_a: got %0d expected %0d", vs_a, VS * HT);
    end
    n_chk++;
    if (vb_cnt != 1 || vb_x != 0 || vb_y != VA) begin
      n_fail++;
      $display("FAIL vblank_tick: got count=%0d at (%0d,%0d) expected count=1 at (0,%0d)",
               vb_cnt, vb_x, vb_y, VA);
    end
  endtask

  task automatic test_async_reset();
    snap_t ea, eb, aa, ab;
    repeat ($urandom_range(HT, FT)) @(negedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    ea = model(0, DA, HPA, VPA);
    eb = model(0, DB, HPB, VPB);
    aa = get_a();
    ab = get_b();
    n_chk++;
    if (aa !== ea) begin
      n_fail++;
      $display("FAIL async_reset_a: got %h expected %h", aa, ea);
    end
    n_chk++;
    if (ab !== eb) begin
      n_fail++;
      $display("FAIL async_reset_b: got %h expected %h", ab, eb);
    end
    repeat (3) @(posedge clk);
    #1;
    aa = get_a();
    n_chk++;
    if (aa !== ea) begin
      n_fail++;
      $display("FAIL reset_hold_a: got %h expected %h", aa, ea);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus_b.pix_x !== '0 || bus_b.pix_y !== '0 || bus_b.frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_b: got x=%0d y=%0d fs=%b expected x=0 y=0 fs=1",
               bus_b.pix_x, bus_b.pix_y, bus_b.frame_start);
    end
  endtask

`ifdef VGA_SCAN_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int guard;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int m = 1; m <= 257; m++) begin
      guard = 0;
      @(negedge clk);
      while (bus_a.frame_start !== 1'b1 && guard < FT + 2) begin
        @(negedge clk);
        guard++;
      end
      n_chk++;
      if (bus_a.frame_start !== 1'b1 || bus_a.frame_cnt !== 8'(m % 256)) begin
        n_fail++;
        $display("FAIL frame_cnt pulse %0d: got fs=%b cnt=%0d expected fs=1 cnt=%0d",
                 m, bus_a.frame_start, bus_a.frame_cnt, m % 256);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_edge();
    test_raster(2 * FT + int'($urandom_range(0, 3 * HT)));
    test_line_hsync();
    test_frame();
    test_async_reset();
    test_raster(FT + int'($urandom_range(0, 2 * HT)));
`ifdef VGA_SCAN_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
